// File: rtl/vga_timing_generator.sv
// VGA timing generator: decodes the upstream pixel counter into hsync and
// active-video, keeps its own line counter and vertical phase, and registers
// every output one clock after h_count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LINE | after reset; outputs idle until the first h_count==H_LAST
// V_ACT     | visible lines 0..V_ACTIVE-1
// V_FRONT   | vertical front porch V_ACTIVE..V_SYNC_START-1
// V_SYNC    | vsync pulse V_SYNC_START..V_SYNC_END-1
// V_BACK    | vertical back porch V_SYNC_END..V_LAST
module vga_timing_generator #(
    parameter int   H_WIDTH      = 11,
    parameter int   V_WIDTH      = 10,
    parameter int   H_ACTIVE     = 1024,
    parameter int   H_SYNC_START = 1048,
    parameter int   H_SYNC_END   = 1184,
    parameter int   H_LAST       = 1328,
    parameter int   V_ACTIVE     = 768,
    parameter int   V_SYNC_START = 771,
    parameter int   V_SYNC_END   = 777,
    parameter int   V_LAST       = 805,
    parameter logic HSYNC_POL    = 1'b0,
    parameter logic VSYNC_POL    = 1'b0
) (
    input  logic               control_clock,
    input  logic               reset,
    input  logic [H_WIDTH-1:0] h_count,
    output logic               hsync,
    output logic               vsync,
    output logic               display_enable,
    output logic [H_WIDTH-1:0] pixel_x,
    output logic [V_WIDTH-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_start
);

    localparam logic [H_WIDTH-1:0] LP_H_ACTIVE     = H_WIDTH'(H_ACTIVE);
    localparam logic [H_WIDTH-1:0] LP_H_SYNC_START = H_WIDTH'(H_SYNC_START);
    localparam logic [H_WIDTH-1:0] LP_H_SYNC_END   = H_WIDTH'(H_SYNC_END);
    localparam logic [H_WIDTH-1:0] LP_H_LAST       = H_WIDTH'(H_LAST);
    localparam logic [V_WIDTH-1:0] LP_V_ACTIVE     = V_WIDTH'(V_ACTIVE);
    localparam logic [V_WIDTH-1:0] LP_V_SYNC_START = V_WIDTH'(V_SYNC_START);
    localparam logic [V_WIDTH-1:0] LP_V_SYNC_END   = V_WIDTH'(V_SYNC_END);
    localparam logic [V_WIDTH-1:0] LP_V_LAST       = V_WIDTH'(V_LAST);

    typedef enum logic [2:0] {
        WAIT_LINE,
        V_ACT,
        V_FRONT,
        V_SYNC,
        V_BACK
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [V_WIDTH-1:0]   r_v_count;
    logic [V_WIDTH-1:0]   w_v_count_next;
    logic [V_WIDTH-1:0]   w_v_inc;
    logic                 w_line_end;
    logic                 w_running;
    logic                 w_h_vis;
    logic                 w_hsync_act;
    logic                 w_de;
    logic                 w_line_start;
    logic                 w_frame_start;

    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_de;
    logic [H_WIDTH-1:0]   r_pixel_x;
    logic [V_WIDTH-1:0]   r_pixel_y;
    logic                 r_line_start;
    logic                 r_frame_start;

    // Vertical phase is a pure function of the line number.
    function automatic state_t phase_of(input logic [V_WIDTH-1:0] v);
        if (v < LP_V_ACTIVE)          return V_ACT;
        else if (v < LP_V_SYNC_START) return V_FRONT;
        else if (v < LP_V_SYNC_END)   return V_SYNC;
        else                          return V_BACK;
    endfunction

    assign w_line_end = (h_count == LP_H_LAST);
    assign w_v_inc    = r_v_count + V_WIDTH'(1);

    // State and line counter register.
    always_ff @(posedge control_clock) begin
        if (reset) begin
            r_state   <= WAIT_LINE;
            r_v_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_v_count <= w_v_count_next;
        end
    end

    // Next state: resync on the first line end, then advance once per line.
    always_comb begin
        w_state_next   = r_state;
        w_v_count_next = r_v_count;
        if (w_line_end) begin
            if (r_state == WAIT_LINE || r_v_count == LP_V_LAST) begin
                w_state_next   = V_ACT;
                w_v_count_next = '0;
            end else begin
                w_state_next   = phase_of(w_v_inc);
                w_v_count_next = w_v_inc;
            end
        end
    end

    // Horizontal decode and strobes; out-of-range h_count falls out as blanking.
    always_comb begin
        w_running     = (r_state != WAIT_LINE);
        w_h_vis       = (h_count < LP_H_ACTIVE);
        w_hsync_act   = w_running && (h_count >= LP_H_SYNC_START) &&
                        (h_count < LP_H_SYNC_END);
        w_de          = w_running && w_h_vis && (r_state == V_ACT);
        w_line_start  = w_running && (h_count == '0);
        w_frame_start = w_line_start && (r_v_count == '0) && (r_state == V_ACT);
    end

    // Output registers: one clock of latency from h_count.
    always_ff @(posedge control_clock) begin
        if (reset) begin
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hsync_act ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= (r_state == V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            r_de          <= w_de;
            r_pixel_x     <= w_de ? h_count : '0;
            r_pixel_y     <= w_de ? r_v_count : '0;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end
    end

    assign hsync          = r_hsync;
    assign vsync          = r_vsync;
    assign display_enable = r_de;
    assign pixel_x        = r_pixel_x;
    assign pixel_y        = r_pixel_y;
    assign line_start     = r_line_start;
    assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Testbench for vga_timing_generator using a shrunk raster so whole frames
// fit in a short run; expected outputs come from a line/pixel model.
module tb_vga_timing_generator;

    localparam int HW  = 11;
    localparam int VW  = 10;
    localparam int HA  = 16;
    localparam int HSS = 20;
    localparam int HSE = 26;
    localparam int HL  = 31;
    localparam int VA  = 12;
    localparam int VSS = 14;
    localparam int VSE = 16;
    localparam int VL  = 19;
    localparam int OW  = 3 + HW + VW + 2;
    localparam int LINE_CYC  = HL + 1;
    localparam int FRAME_CYC = (VL + 1) * LINE_CYC;

    logic          clk = 1'b0;
    logic          rst;
    logic [HW-1:0] h;
    logic          hsync, vsync, de, ls, fs;
    logic [HW-1:0] px;
    logic [VW-1:0] py;

    always #5 clk = ~clk;

    vga_timing_generator #(
        .H_WIDTH(HW), .V_WIDTH(VW), .H_ACTIVE(HA), .H_SYNC_START(HSS),
        .H_SYNC_END(HSE), .H_LAST(HL), .V_ACTIVE(VA), .V_SYNC_START(VSS),
        .V_SYNC_END(VSE), .V_LAST(VL), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .control_clock(clk), .reset(rst), .h_count(h),
        .hsync(hsync), .vsync(vsync), .display_enable(de),
        .pixel_x(px), .pixel_y(py), .line_start(ls), .frame_start(fs)
    );

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            h_pos = 0;
    bit            m_run = 0;
    int            m_line = 0;
    logic [OW-1:0] exp_o;
    logic [OW-1:0] act_o;

    assign act_o = {hsync, vsync, de, px, py, ls, fs};

    function automatic logic [OW-1:0] idle_out();
        return {1'b1, 1'b1, 1'b0, {HW{1'b0}}, {VW{1'b0}}, 1'b0, 1'b0};
    endfunction

    // Raster model: what the pins should show for pixel hv of the given line.
    function automatic logic [OW-1:0] model_out(input int hv, input bit run, input int line);
        logic          e_de, e_hs, e_vs, e_ls, e_fs;
        logic [HW-1:0] e_px;
        logic [VW-1:0] e_py;
        if (!run) return idle_out();
        e_de = (hv < HA) && (line < VA);
        e_hs = (hv >= HSS && hv < HSE) ? 1'b0 : 1'b1;
        e_vs = (line >= VSS && line < VSE) ? 1'b0 : 1'b1;
        e_ls = (hv == 0);
        e_fs = e_ls && (line == 0);
        e_px = e_de ? HW'(hv) : '0;
        e_py = e_de ? VW'(line) : '0;
        return {e_hs, e_vs, e_de, e_px, e_py, e_ls, e_fs};
    endfunction

    // Apply one clock of stimulus and compute what should appear after it.
    task automatic step(input int hv, input bit r);
        h   = HW'(hv);
        rst = r;
        if (r) begin
            exp_o  = idle_out();
            m_run  = 0;
            m_line = 0;
        end else begin
            exp_o = model_out(hv, m_run, m_line);
            if (hv == HL) begin
                if (!m_run) begin
                    m_run  = 1;
                    m_line = 0;
                end else begin
                    m_line = (m_line == VL) ? 0 : m_line + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ramp(input bit r);
        step(h_pos, r);
        h_pos = (h_pos == HL) ? 0 : h_pos + 1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(int'($urandom_range(0, 2047)), 1'b1);
            n_vec++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, act_o, exp_o);
            end
        end
    endtask

    task automatic test_resync();
        h_pos = int'($urandom_range(1, HL - 1));
        while (h_pos != 0) begin
            ramp(1'b0);
            n_vec++;
            if (act_o !== idle_out()) begin
                n_err++;
                $display("FAIL resync_idle cyc=%0d got=%h exp=%h", cyc, act_o, idle_out());
            end
        end
        ramp(1'b0);
        n_vec++;
        if (fs !== 1'b1 || ls !== 1'b1) begin
            n_err++;
            $display("FAIL resync_first_frame got fs=%b ls=%b exp fs=1 ls=1", fs, ls);
        end
        for (int i = 0; i < 2 * LINE_CYC; i++) begin
            ramp(1'b0);
            n_vec++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL resync_line cyc=%0d got=%h exp=%h", cyc, act_o, exp_o);
            end
        end
    endtask

    task automatic test_full_frames();
        int n_ls, n_fs, n_vs, n_de, n_hs, max_py, fs_at, guard;
        guard = 0;
        while (fs !== 1'b1 && guard < FRAME_CYC + 2) begin
            ramp(1'b0);
            guard++;
        end
        n_vec++;
        if (fs !== 1'b1) begin
            n_err++;
            $display("FAIL frame_wait got fs=%b exp fs=1 within %0d cycles", fs, FRAME_CYC + 2);
        end
        for (int f = 0; f < 2; f++) begin
            n_ls = 0; n_fs = 0; n_vs = 0; n_de = 0; n_hs = 0; max_py = 0; fs_at = -1;
            for (int i = 1; i <= FRAME_CYC; i++) begin
                ramp(1'b0);
                n_vec++;
                if (act_o !== exp_o) begin
                    n_err++;
                    $display("FAIL frame_px cyc=%0d got=%h exp=%h", cyc, act_o, exp_o);
                end
                n_ls += int'(ls);
                n_fs += int'(fs);
                n_vs += int'(!vsync);
                n_de += int'(de);
                n_hs += int'(!hsync);
                if (int'(py) > max_py) max_py = int'(py);
                if (fs === 1'b1) fs_at = i;
            end
            n_vec++;
            if (n_ls !== VL + 1 || n_fs !== 1 || fs_at !== FRAME_CYC) begin
                n_err++;
                $display("FAIL frame_strobes got ls=%0d fs=%0d at=%0d exp ls=%0d fs=1 at=%0d",
                         n_ls, n_fs, fs_at, VL + 1, FRAME_CYC);
            end
            n_vec++;
            if (n_vs !== (VSE - VSS) * LINE_CYC || n_hs !== (HSE - HSS) * (VL + 1)) begin
                n_err++;
                $display("FAIL frame_sync got vs=%0d hs=%0d exp vs=%0d hs=%0d",
                         n_vs, n_hs, (VSE - VSS) * LINE_CYC, (HSE - HSS) * (VL + 1));
            end
            n_vec++;
            if (n_de !== VA * HA || max_py !== VA - 1) begin
                n_err++;
                $display("FAIL frame_active got de=%0d max_y=%0d exp de=%0d max_y=%0d",
                         n_de, max_py, VA * HA, VA - 1);
            end
        end
    endtask

    task automatic test_out_of_range();
        int k;
        while (h_pos != 5) ramp(1'b0);
        k = int'($urandom_range(8, 12));
        for (int i = 0; i < k; i++) begin
            step(int'($urandom_range(HL + 1, 2047)), 1'b0);
            n_vec++;
            if (act_o !== exp_o || de !== 1'b0 || hsync !== 1'b1) begin
                n_err++;
                $display("FAIL out_of_range cyc=%0d got=%h exp=%h", cyc, act_o, exp_o);
            end
        end
        for (int i = 0; i < 3 * LINE_CYC; i++) begin
            ramp(1'b0);
            n_vec++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL oor_resume cyc=%0d got=%h exp=%h", cyc, act_o, exp_o);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int k, n_fs;
        k = int'($urandom_range(100, 400));
        for (int i = 0; i < k; i++) ramp(1'b0);
        ramp(1'b1);
        n_vec++;
        if (act_o !== idle_out()) begin
            n_err++;
            $display("FAIL mid_reset cyc=%0d got=%h exp=%h", cyc, act_o, idle_out());
        end
        n_fs = 0;
        for (int i = 0; i < FRAME_CYC + 2 * LINE_CYC; i++) begin
            ramp(1'b0);
            n_fs += int'(fs);
            n_vec++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL mid_reset_run cyc=%0d got=%h exp=%h", cyc, act_o, exp_o);
            end
        end
        n_vec++;
        if (n_fs < 1) begin
            n_err++;
            $display("FAIL mid_reset_restart got fs_count=%0d exp >=1", n_fs);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                ramp(1'b1);
            end else if (r < 14) begin
                h_pos = int'($urandom_range(0, 63));
                ramp(1'b0);
            end else begin
                ramp(1'b0);
            end
            if (h_pos > HL) h_pos = 0;
            n_vec++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_o, exp_o);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        h   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_resync();
        test_full_frames();
        test_out_of_range();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
